fifo_level: RTL and testbench

//  Synchronous single-clock FIFO; next generation of the team FIFO.

---
 rtl/fifo_level.sv | 72 +++++++
 tb/tb_fifo_level.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fifo_level.sv
// fifo_level: single-clock FIFO with fill level, programmable almost flags,
// sticky overflow/underflow and registered or fall-through read data.
module fifo_level #(
    parameter int bitWidth         = 32,
    parameter int nrOfEntries      = 16,
    parameter int almostFullLevel  = 12,
    parameter int almostEmptyLevel = 4,
    parameter bit fallThrough      = 1'b0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push,
    input  logic [bitWidth-1:0]              pushData,
    input  logic                             pop,
    output logic [bitWidth-1:0]              popData,
    output logic                             full,
    output logic                             empty,
    output logic                             almostFull,
    output logic                             almostEmpty,
    output logic [$clog2(nrOfEntries):0]     fillCount,
    output logic                             overflow,
    output logic                             underflow,
    input  logic                             clearErrors
);
    localparam int AW = $clog2(nrOfEntries);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(nrOfEntries);
    localparam logic [CW-1:0] AF    = CW'(almostFullLevel);
    localparam logic [CW-1:0] AE    = CW'(almostEmptyLevel);

    logic [bitWidth-1:0] mem [nrOfEntries];
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic                pop_acc, push_acc, inc, dec;

    assign pop_acc     = pop & ~empty;
    assign push_acc    = push & (~full | pop_acc);
    assign inc         = push_acc & ~pop_acc;
    assign dec         = pop_acc & ~push_acc;
    assign empty       = fillCount == '0;
    assign full        = fillCount == DEPTH;
    assign almostFull  = fillCount >= AF;
    assign almostEmpty = fillCount <= AE;

    always_ff @(posedge clock)
        if (push_acc) mem[wr_ptr] <= pushData;

    // a new error event outranks a same-cycle clear
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fillCount <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc) rd_ptr <= rd_ptr + 1'b1;
            fillCount <= fillCount + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
            overflow  <= (push & ~push_acc) | (overflow & ~clearErrors);
            underflow <= (pop & empty) | (underflow & ~clearErrors);
        end

    generate
        if (fallThrough) begin : g_fwft
            assign popData = mem[rd_ptr];
        end else begin : g_reg
            always_ff @(posedge clock or negedge reset)
                if (!reset) popData <= '0;
                else if (pop_acc) popData <= mem[rd_ptr];
        end
    endgenerate
endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed checks of the registered-read FIFO plus a
// fall-through instance sharing clock and reset.
module tb_fifo_level;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0, pop = 1'b0, clr = 1'b0;
    logic [31:0] push_data = '0, pop_data;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  fill_count;
    logic        f_push = 1'b0, f_pop = 1'b0;
    logic [31:0] f_data = '0, f_pop_data;
    logic        f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0]  f_count;
    int          tests = 0, failed = 0;

    always #5 clock = ~clock;

    fifo_level u_dut (
        .clock(clock), .reset(reset), .push(push), .pushData(push_data),
        .pop(pop), .popData(pop_data), .full(full), .empty(empty),
        .almostFull(almost_full), .almostEmpty(almost_empty),
        .fillCount(fill_count), .overflow(overflow), .underflow(underflow),
        .clearErrors(clr)
    );

    fifo_level #(.fallThrough(1'b1)) u_ft (
        .clock(clock), .reset(reset), .push(f_push), .pushData(f_data),
        .pop(f_pop), .popData(f_pop_data), .full(f_full), .empty(f_empty),
        .almostFull(f_af), .almostEmpty(f_ae), .fillCount(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clearErrors(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_count", fill_count, 0);
        chk("rst_popdata", pop_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        #10 reset = 1'b1;
        // fill to 16
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; push_data = 32'(i);
            tick();
            chk("fill_count", fill_count, 64'(i));
            chk("fill_afull", almost_full, (i >= 12));
            chk("fill_aempty", almost_empty, (i <= 4));
            chk("fill_full", full, (i == 16));
        end
        // push while full
        push_data = 32'h99;
        tick();
        push = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", fill_count, 16);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_clear", overflow, 0);
        // push and pop together while full
        push = 1'b1; push_data = 32'hAA; pop = 1'b1;
        tick();
        push = 1'b0;
        chk("pp_count", fill_count, 16);
        chk("pp_ovf", overflow, 0);
        chk("pp_data", pop_data, 1);
        for (int i = 2; i <= 17; i++) begin
            tick();
            chk("drain_data", pop_data, (i == 17) ? 64'hAA : 64'(i));
        end
        chk("drain_empty", empty, 1);
        chk("drain_count", fill_count, 0);
        tick();
        pop = 1'b0;
        chk("unf_set", underflow, 1);
        chk("unf_hold", pop_data, 64'hAA);
        chk("unf_count", fill_count, 0);
        // set beats clear
        pop = 1'b1; clr = 1'b1;
        tick();
        pop = 1'b0;
        chk("set_wins", underflow, 1);
        tick();
        clr = 1'b0;
        chk("unf_clear", underflow, 0);
        // push + pop on empty: pop refused, push taken
        push = 1'b1; pop = 1'b1; push_data = 32'h33;
        tick();
        push = 1'b0;
        chk("pe_count", fill_count, 1);
        chk("pe_unf", underflow, 1);
        chk("pe_hold", pop_data, 64'hAA);
        tick();
        pop = 1'b0;
        chk("pe_data", pop_data, 64'h33);
        chk("pe_empty", empty, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        // asynchronous reset mid-stream
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; push_data = 32'(100 + i);
            tick();
        end
        push = 1'b0;
        chk("pre_rst_count", fill_count, 10);
        #2 reset = 1'b0;
        #1;
        chk("arst_count", fill_count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_popdata", pop_data, 0);
        chk("arst_unf", underflow, 0);
        #1 reset = 1'b1;
        push = 1'b1; push_data = 32'h7;
        tick();
        push = 1'b0; pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("post_rst_data", pop_data, 7);
        chk("post_rst_empty", empty, 1);
        // fall-through instance
        f_push = 1'b1; f_data = 32'h5;
        tick();
        f_push = 1'b0;
        chk("ft_data", f_pop_data, 5);
        chk("ft_nempty", f_empty, 0);
        tick();
        chk("ft_hold", f_pop_data, 5);
        f_push = 1'b1; f_data = 32'h6;
        tick();
        f_push = 1'b0; f_pop = 1'b1;
        tick();
        chk("ft_next", f_pop_data, 6);
        chk("ft_count", f_count, 1);
        tick();
        f_pop = 1'b0;
        chk("ft_empty", f_empty, 1);
        chk("ft_zero", f_count, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
